seven_disp_scan_ctrl: RTL

Time-multiplexing scan scheduler for the SevenDispManager seven-segment display. It shares one set of segment lines between NUM_DIGITS digits by sequencing the digit anodes one slot at a time. Within each slot it inserts an anti-ghosting blank window and applies PWM brightness. It sits between the AXI4-Lite register file, which supplies its configuration inputs, and the board pins.

---
 rtl/seven_disp_scan_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seven_disp_scan_ctrl.sv
// Seven-segment scan scheduler: walks the digit anodes one slot at a time, with an
// anti-ghost blank window and PWM brightness in each slot, and a frame-aligned config double-buffer.
//
// state    | meaning
// ST_IDLE  | scan held, display dark, counters parked at 0
// ST_BLANK | first BLANK_CYCLES of a slot, all anodes off
// ST_LIT   | rest of the slot, current digit driven under PWM
module seven_disp_scan_ctrl #(
   parameter int NUM_DIGITS   = 8,
   parameter int PRESCALE     = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_enable,
   input  logic                    i_cfg_load,
   input  logic [4*NUM_DIGITS-1:0] i_cfg_digits,
   input  logic [NUM_DIGITS-1:0]   i_cfg_dp,
   input  logic [NUM_DIGITS-1:0]   i_cfg_en,
   input  logic [3:0]              i_cfg_bright,
   output logic [NUM_DIGITS-1:0]   o_an,
   output logic [6:0]              o_seg,
   output logic                    o_dp,
   output logic                    o_frame_done,
   output logic                    o_cfg_pending
);

   localparam int SLOT_W  = $clog2(PRESCALE);
   localparam int DIGIT_W = $clog2(NUM_DIGITS);
   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(PRESCALE - 1);
   localparam logic [SLOT_W-1:0]  BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
   localparam logic [SLOT_W-1:0]  BLANK_LEN  = SLOT_W'(BLANK_CYCLES);
   localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_LIT} state_t;

   state_t                  r_state;
   logic [SLOT_W-1:0]       r_slot_cnt;
   logic [DIGIT_W-1:0]      r_digit_idx;
   logic [3:0]              r_pwm_cnt;
   logic [4*NUM_DIGITS-1:0] r_act_digits;
   logic [NUM_DIGITS-1:0]   r_act_dp;
   logic [NUM_DIGITS-1:0]   r_act_en;
   logic [3:0]              r_act_bright;
   logic [4*NUM_DIGITS-1:0] r_pend_digits;
   logic [NUM_DIGITS-1:0]   r_pend_dp;
   logic [NUM_DIGITS-1:0]   r_pend_en;
   logic [3:0]              r_pend_bright;
   logic                    r_pend_valid;

   logic                    w_slot_wrap;
   logic                    w_frame_end;
   logic [SLOT_W-1:0]       w_slot_nxt;
   logic [3:0]              w_nibble;
   logic                    w_lit;
   logic [NUM_DIGITS-1:0]   w_an_lit;
   logic [6:0]              w_seg_dec;

   always_comb begin
      w_slot_wrap = (r_slot_cnt == SLOT_LAST);
      w_frame_end = (r_state != ST_IDLE) && w_slot_wrap && (r_digit_idx == DIGIT_LAST);
      w_slot_nxt  = w_slot_wrap ? '0 : r_slot_cnt + SLOT_W'(1);
      w_nibble    = r_act_digits[{r_digit_idx, 2'b00} +: 4];
      w_lit       = (r_state == ST_LIT) && r_act_en[r_digit_idx] && (r_pwm_cnt <= r_act_bright);
      w_an_lit    = ~(NUM_DIGITS'(1) << r_digit_idx);
   end

   always_comb begin
      w_seg_dec = 7'h7F;
      case (w_nibble)
         4'h0: w_seg_dec = 7'h40;
         4'h1: w_seg_dec = 7'h79;
         4'h2: w_seg_dec = 7'h24;
         4'h3: w_seg_dec = 7'h30;
         4'h4: w_seg_dec = 7'h19;
         4'h5: w_seg_dec = 7'h12;
         4'h6: w_seg_dec = 7'h02;
         4'h7: w_seg_dec = 7'h78;
         4'h8: w_seg_dec = 7'h00;
         4'h9: w_seg_dec = 7'h10;
         4'hA: w_seg_dec = 7'h08;
         4'hB: w_seg_dec = 7'h03;
         4'hC: w_seg_dec = 7'h46;
         4'hD: w_seg_dec = 7'h21;
         4'hE: w_seg_dec = 7'h06;
         4'hF: w_seg_dec = 7'h0E;
         default: w_seg_dec = 7'h7F;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_slot_cnt    <= '0;
         r_digit_idx   <= '0;
         r_pwm_cnt     <= '0;
         r_act_digits  <= '0;
         r_act_dp      <= '0;
         r_act_en      <= '0;
         r_act_bright  <= '0;
         r_pend_digits <= '0;
         r_pend_dp     <= '0;
         r_pend_en     <= '0;
         r_pend_bright <= '0;
         r_pend_valid  <= 1'b0;
         o_an          <= '1;
         o_seg         <= 7'h7F;
         o_dp          <= 1'b1;
         o_frame_done  <= 1'b0;
      end else begin
         // Apply pending config only where no slot is mid-display; a same-cycle load re-arms pending.
         if ((r_state == ST_IDLE || (i_enable && w_frame_end)) && r_pend_valid) begin
            r_act_digits <= r_pend_digits;
            r_act_dp     <= r_pend_dp;
            r_act_en     <= r_pend_en;
            r_act_bright <= r_pend_bright;
            r_pend_valid <= 1'b0;
         end
         if (i_cfg_load) begin
            r_pend_digits <= i_cfg_digits;
            r_pend_dp     <= i_cfg_dp;
            r_pend_en     <= i_cfg_en;
            r_pend_bright <= i_cfg_bright;
            r_pend_valid  <= 1'b1;
         end

         o_frame_done <= i_enable && w_frame_end;
         o_an         <= '1;
         o_seg        <= 7'h7F;
         o_dp         <= 1'b1;

         if (!i_enable) begin
            r_state     <= ST_IDLE;
            r_slot_cnt  <= '0;
            r_digit_idx <= '0;
            r_pwm_cnt   <= '0;
         end else begin
            if (w_lit) begin
               o_an  <= w_an_lit;
               o_seg <= w_seg_dec;
               o_dp  <= ~r_act_dp[r_digit_idx];
            end
            case (r_state)
               ST_IDLE: begin
                  r_state     <= ST_BLANK;
                  r_slot_cnt  <= '0;
                  r_digit_idx <= '0;
                  r_pwm_cnt   <= '0;
               end
               default: begin
                  r_slot_cnt <= w_slot_nxt;
                  if (w_slot_wrap)
                     r_digit_idx <= (r_digit_idx == DIGIT_LAST) ? '0 : r_digit_idx + DIGIT_W'(1);
                  // PWM phase restarts exactly as the slot turns lit
                  if (r_slot_cnt == BLANK_LAST)
                     r_pwm_cnt <= '0;
                  else if (r_state == ST_LIT)
                     r_pwm_cnt <= r_pwm_cnt + 4'd1;
                  r_state <= (w_slot_nxt < BLANK_LEN) ? ST_BLANK : ST_LIT;
               end
            endcase
         end
      end
   end

   assign o_cfg_pending = r_pend_valid;

endmodule
